// File: rtl/pipe_memory.sv
// Y86-64 memory stage: E/M pipeline register plus byte-addressed data memory (8-byte LE words).
// Data memory starts all-zero at time zero.
module pipe_memory #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat,
  output logic        dmem_error
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hf;

  logic [7:0] mem [0:MEM_BYTES-1] = '{default: 8'h00};

  logic [3:0]  stat_q,  stat_d;
  logic [3:0]  icode_q, icode_d;
  logic        cnd_q,   cnd_d;
  logic [63:0] valE_q,  valE_d;
  logic [63:0] valA_q,  valA_d;
  logic [3:0]  dstE_q,  dstE_d;
  logic [3:0]  dstM_q,  dstM_d;
  // Drops after the first stalled edge so a held store commits exactly once.
  logic        armed_q, armed_d;

  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    valE_d  = valE_q;
    valA_d  = valA_q;
    dstE_d  = dstE_q;
    dstM_d  = dstM_q;
    armed_d = 1'b1;
    if (M_bubble) begin
      stat_d  = STAT_AOK;
      icode_d = I_NOP;
      cnd_d   = 1'b0;
      valE_d  = '0;
      valA_d  = '0;
      dstE_d  = REG_NONE;
      dstM_d  = REG_NONE;
    end else if (M_stall) begin
      armed_d = 1'b0;
    end else begin
      stat_d  = e_stat;
      icode_d = e_icode;
      cnd_d   = e_cnd;
      valE_d  = e_valE;
      valA_d  = e_valA;
      dstE_d  = e_dstE;
      dstM_d  = e_dstM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q  <= STAT_AOK;
      icode_q <= I_NOP;
      cnd_q   <= 1'b0;
      valE_q  <= '0;
      valA_q  <= '0;
      dstE_q  <= REG_NONE;
      dstM_q  <= REG_NONE;
      armed_q <= 1'b1;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      valE_q  <= valE_d;
      valA_q  <= valA_d;
      dstE_q  <= dstE_d;
      dstM_q  <= dstM_d;
      armed_q <= armed_d;
    end
  end

  logic          is_rd, is_wr, addr_ok, mem_we;
  logic [63:0]   addr;
  logic [AW-1:0] idx;
  logic [63:0]   rd_dat;

  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    addr  = valE_q;
    case (icode_q)
      I_RMMOVQ, I_CALL, I_PUSHQ: is_wr = 1'b1;
      I_MRMOVQ:                  is_rd = 1'b1;
      I_RET, I_POPQ: begin
        is_rd = 1'b1;
        addr  = valA_q;
      end
      default: ;
    endcase
  end

  // Unsigned compare: huge addresses are errors, never wrapped into the array.
  assign addr_ok    = (addr <= ADDR_MAX);
  assign dmem_error = (is_rd | is_wr) & ~addr_ok;
  assign idx        = addr_ok ? addr[AW-1:0] : '0;
  assign mem_we     = is_wr & addr_ok & (stat_q == STAT_AOK) & armed_q & rst_n;

  always_comb begin
    rd_dat = '0;
    if (is_rd && addr_ok) begin
      for (int i = 0; i < 8; i++) begin
        rd_dat[8*i +: 8] = mem[idx + AW'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + AW'(i)] <= valA_q[8*i +: 8];
      end
    end
  end

  assign M_stat  = stat_q;
  assign M_icode = icode_q;
  assign M_cnd   = cnd_q;
  assign M_valE  = valE_q;
  assign M_valA  = valA_q;
  assign M_dstE  = dstE_q;
  assign M_dstM  = dstM_q;
  assign m_valM  = rd_dat;
  assign m_stat  = dmem_error ? STAT_ADR : stat_q;

endmodule

// File: tb/tb_pipe_memory.sv
// Directed bench for pipe_memory: reset, store/load, stall/bubble, bounds, ret/popq, non-AOK store.
module tb_pipe_memory;

  localparam int MEM_BYTES = 1024;

  logic        clk, rst_n, M_stall, M_bubble, e_cnd, M_cnd, dmem_error;
  logic [3:0]  e_stat, e_icode, e_dstE, e_dstM;
  logic [63:0] e_valE, e_valA;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM, m_stat;
  logic [63:0] M_valE, M_valA, m_valM;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int wr_base;

  pipe_memory #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd), .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_valM(m_valM), .m_stat(m_stat), .dmem_error(dmem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-cycle sample of the write strobe: a 1 here means a write commits on the next rising edge.
  always @(negedge clk) if (dut.mem_we) wr_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    e_stat = st; e_icode = ic; e_valE = ve; e_valA = va; e_dstE = de; e_dstM = dm;
  endtask

  task automatic load(input logic [3:0] st, input logic [3:0] ic, input logic [63:0] ve,
                      input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    drive(st, ic, ve, va, de, dm);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0; e_cnd = 1'b0;
    drive(4'h1, 4'h1, 64'h0, 64'h0, 4'hf, 4'hf);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset asserted mid-cycle, including during a pending store
    e_cnd = 1'b1;
    load(4'h1, 4'h3, 64'h99, 64'h0, 4'h2, 4'hf);
    check("cnd_pass", M_cnd, 1'b1);
    e_cnd = 1'b0;
    load(4'h1, 4'h4, 64'h30, 64'hCAFE, 4'hf, 4'hf);
    #2 rst_n = 1'b0;
    #1;
    check("rst_icode", M_icode, 4'h1);
    check("rst_dstE", M_dstE, 4'hf);
    check("rst_dstM", M_dstM, 4'hf);
    check("rst_stat", M_stat, 4'h1);
    check("rst_mstat", m_stat, 4'h1);
    check("rst_err", dmem_error, 1'b0);
    check("rst_valE", M_valE, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_nowrite", dut.mem[48], 8'h00);

    // Store then load, plus an unaligned read across the stored word
    load(4'h1, 4'h4, 64'h10, 64'h1122334455667788, 4'hf, 4'hf);
    check("st_err", dmem_error, 1'b0);
    check("st_valM", m_valM, 64'h0);
    load(4'h1, 4'h5, 64'h10, 64'h0, 4'hf, 4'h3);
    check("ld_valM", m_valM, 64'h1122334455667788);
    check("ld_byte10", dut.mem[16], 8'h88);
    check("ld_byte17", dut.mem[23], 8'h11);
    check("ld_mstat", m_stat, 4'h1);
    load(4'h1, 4'h5, 64'h13, 64'h0, 4'hf, 4'h3);
    check("ld_unaligned", m_valM, 64'h0000001122334455);

    // Stalled pushq writes exactly once, then stall+bubble loads a bubble
    wr_base = wr_cnt;
    load(4'h1, 4'hA, 64'h20, 64'h55, 4'h4, 4'hf);
    M_stall = 1'b1;
    drive(4'h1, 4'h1, 64'h0, 64'h0, 4'hf, 4'hf);
    repeat (3) @(posedge clk);
    #1;
    check("stall_icode", M_icode, 4'hA);
    check("stall_valE", M_valE, 64'h20);
    check("stall_valA", M_valA, 64'h55);
    check("stall_dstE", M_dstE, 4'h4);
    check("stall_mem", dut.mem[32], 8'h55);
    check("stall_writes", 64'(wr_cnt - wr_base), 64'd1);
    M_bubble = 1'b1;
    drive(4'h1, 4'h5, 64'h77, 64'h0, 4'h3, 4'h3);
    @(posedge clk); #1;
    check("bub_icode", M_icode, 4'h1);
    check("bub_dstE", M_dstE, 4'hf);
    check("bub_dstM", M_dstM, 4'hf);
    check("bub_valE", M_valE, 64'h0);
    check("bub_err", dmem_error, 1'b0);
    M_stall = 1'b0; M_bubble = 1'b0;

    // Bounds
    load(4'h1, 4'h5, 64'(MEM_BYTES - 8), 64'h0, 4'hf, 4'h3);
    check("bnd_last_err", dmem_error, 1'b0);
    load(4'h1, 4'h5, 64'(MEM_BYTES - 7), 64'h0, 4'hf, 4'h3);
    check("bnd_over_err", dmem_error, 1'b1);
    check("bnd_over_mstat", m_stat, 4'h3);
    check("bnd_over_valM", m_valM, 64'h0);
    wr_base = wr_cnt;
    load(4'h1, 4'h4, 64'hFFFFFFFFFFFFFFF8, 64'hDEAD, 4'hf, 4'hf);
    check("bnd_neg_err", dmem_error, 1'b1);
    check("bnd_neg_mstat", m_stat, 4'h3);
    load(4'h1, 4'h1, 64'h0, 64'h0, 4'hf, 4'hf);
    check("bnd_neg_nowrite", 64'(wr_cnt - wr_base), 64'd0);
    check("bnd_neg_nowrap", dut.mem[1016], 8'h00);

    // ret/popq address through valA
    load(4'h1, 4'h4, 64'h40, 64'hABCD, 4'hf, 4'hf);
    load(4'h1, 4'h9, 64'h100, 64'h40, 4'h4, 4'hf);
    check("ret_valM", m_valM, 64'hABCD);
    load(4'h1, 4'hB, 64'h200, 64'h40, 4'h4, 4'h5);
    check("pop_valM", m_valM, 64'hABCD);

    // Non-AOK store leaves memory untouched
    load(4'h2, 4'h4, 64'h40, 64'h77, 4'hf, 4'hf);
    check("hlt_mstat", m_stat, 4'h2);
    check("hlt_err", dmem_error, 1'b0);
    load(4'h1, 4'h5, 64'h40, 64'h0, 4'hf, 4'h3);
    check("hlt_nochange", m_valM, 64'hABCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
